// File: rtl/calib_pkg.sv
// calib_pkg: shared state encodings, counter width, mode values and period clamp for the calibration pulse path
package calib_pkg;
    typedef enum logic [1:0] {CS_IDLE, CS_HIGH, CS_GAP, CS_FINISH} cs_t;
    localparam int CNT_W = 12;
    localparam logic CAL_INJ = 1'b1;
    localparam logic CAL_EXT = 1'b0;
    // The period must leave room for the pulse, the whole trigger window and one cycle to book the result.
    function automatic logic [15:0] clamp_period(input logic [15:0] period, input logic [3:0] pw,
                                                 input logic [7:0] dly, input logic [3:0] len);
        logic [15:0] need;
        need = 16'(pw) + 16'(dly) + 16'(len) + 16'd1;
        return period > need ? period : need;
    endfunction
endpackage

// File: rtl/calib_pulse_seq_trg_win_chk.sv
// trg_win_chk: synchronises the returned trigger and flags a hit inside the per-pulse window
module trg_win_chk #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trg_pulse,
    input  logic        clr,
    input  logic [15:0] pc,
    input  logic [7:0]  dly,
    input  logic [3:0]  len,
    output logic        hit
);
    logic [SYNC_STAGES-1:0] sync;
    logic trg_s, in_win;
    assign trg_s = sync[SYNC_STAGES-1];
    assign in_win = pc >= 16'(dly) && pc < 16'(dly) + 16'(len);
    always_ff @(posedge clk)
        if (rst) begin
            sync <= '0;
            hit <= 1'b0;
        end else begin
            sync <= (sync << 1) | SYNC_STAGES'(trg_pulse);
            hit <= !clr && (hit || (trg_s && in_win));
        end
endmodule

// File: rtl/calib_pulse_seq.sv
// calib_pulse_seq: programmable calibration pulse train with per-pulse trigger hit/miss accounting
module calib_pulse_seq
    import calib_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK40,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic             CAL_MODE_IN,
    input  logic [11:0]      NPULSE,
    input  logic [3:0]       PWIDTH,
    input  logic [15:0]      PERIOD,
    input  logic [7:0]       TRG_DLY,
    input  logic [3:0]       TRG_LEN,
    input  logic             TRG_PULSE,
    output logic             FEM_INJPLS,
    output logic             CAL_MODE,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] SENT_CNT,
    output logic [CNT_W-1:0] HIT_CNT,
    output logic [CNT_W-1:0] MISS_CNT
);
    cs_t state, state_n;
    logic [15:0] pc, pc_n, pe, pe_n;
    logic [3:0] pw, pw_n, len, len_n;
    logic [7:0] dly, dly_n;
    logic [CNT_W-1:0] np, np_n, sent_n, hit_n, miss_n;
    logic mode_n, fem_n, busy_n, done_n, last, hit_flag, clr;

    assign last = pc == pe - 16'd1;
    assign clr = state == CS_IDLE || (state == CS_GAP && last);

    trg_win_chk #(.SYNC_STAGES(SYNC_STAGES)) u_win (
        .clk(CLK40), .rst(RST), .trg_pulse(TRG_PULSE), .clr(clr),
        .pc(pc), .dly(dly), .len(len), .hit(hit_flag)
    );

    always_ff @(posedge CLK40)
        if (RST) begin
            state <= CS_IDLE;
            pc <= '0;
            pe <= '0;
            pw <= '0;
            len <= '0;
            dly <= '0;
            np <= '0;
            FEM_INJPLS <= 1'b0;
            CAL_MODE <= CAL_EXT;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            SENT_CNT <= '0;
            HIT_CNT <= '0;
            MISS_CNT <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            pe <= pe_n;
            pw <= pw_n;
            len <= len_n;
            dly <= dly_n;
            np <= np_n;
            FEM_INJPLS <= fem_n;
            CAL_MODE <= mode_n;
            BUSY <= busy_n;
            DONE <= done_n;
            SENT_CNT <= sent_n;
            HIT_CNT <= hit_n;
            MISS_CNT <= miss_n;
        end

    always_comb begin
        state_n = state;
        pc_n = pc + 16'd1;
        pe_n = pe;
        pw_n = pw;
        len_n = len;
        dly_n = dly;
        np_n = np;
        sent_n = SENT_CNT;
        hit_n = HIT_CNT;
        miss_n = MISS_CNT;
        mode_n = CAL_MODE;
        if (ABORT)
            state_n = CS_IDLE;
        else
            case (state)
                CS_IDLE:
                    if (START && !BUSY) begin
                        np_n = NPULSE;
                        pw_n = PWIDTH == 4'd0 ? 4'd1 : PWIDTH;
                        len_n = TRG_LEN == 4'd0 ? 4'd1 : TRG_LEN;
                        dly_n = TRG_DLY;
                        pe_n = clamp_period(PERIOD, pw_n, TRG_DLY, len_n);
                        mode_n = CAL_MODE_IN ? CAL_INJ : CAL_EXT;
                        pc_n = '0;
                        hit_n = '0;
                        miss_n = '0;
                        sent_n = NPULSE == '0 ? '0 : CNT_W'(1);
                        state_n = NPULSE == '0 ? CS_FINISH : CS_HIGH;
                    end
                CS_HIGH: state_n = pc == 16'(pw) - 16'd1 ? CS_GAP : CS_HIGH;
                CS_GAP:
                    if (last) begin
                        hit_n = hit_flag ? HIT_CNT + 1'b1 : HIT_CNT;
                        miss_n = hit_flag ? MISS_CNT : MISS_CNT + 1'b1;
                        pc_n = '0;
                        sent_n = SENT_CNT < np ? SENT_CNT + 1'b1 : SENT_CNT;
                        state_n = SENT_CNT < np ? CS_HIGH : CS_FINISH;
                    end
                CS_FINISH: state_n = CS_IDLE;
            endcase
        fem_n = state_n == CS_HIGH;
        done_n = !ABORT && state == CS_FINISH;
        // BUSY stays up through the DONE cycle so a new START cannot overlap the strobe.
        busy_n = !ABORT && (state_n != CS_IDLE || state == CS_FINISH);
    end
endmodule
